score_keeper: RTL and testbench

// Producer side of the 3-bit score interface read by the 7-segment score display.
// - Synchronizes and debounces two raw player buttons.
// - Awards one point per accepted press.
// - Enforces a lockout between points and freezes both scores once a player reaches WIN_SCORE.
// - Sits between the board pushbuttons and the display driver; p1/p2 wire directly to the display.
//

---
 rtl/score_keeper.sv | 159 +++++++++++++++
 tb/tb_score_keeper.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: debounces two player buttons, awards points, enforces a
// lockout between points and freezes the scores once a player wins.
// p1/p2 feed the 7-segment score display directly.
module score_keeper #(
   parameter logic [2:0] WIN_SCORE   = 3'd5,
   parameter int         DB_CYCLES   = 50000,
   parameter int         LOCK_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       p1_btn,
   input  logic       p2_btn,
   input  logic       new_game,
   output logic [2:0] p1,
   output logic [2:0] p2,
   output logic       game_over,
   output logic [1:0] winner,
   output logic       locked
);

   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int LKW = $clog2(LOCK_CYCLES + 1);

   // Debounce count at which the debounced level flips on this edge.
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
   localparam logic [DBW-1:0] DB_ONE   = DBW'(1);
   localparam logic [LKW-1:0] LK_LOAD  = LKW'(LOCK_CYCLES - 1);
   localparam logic [LKW-1:0] LK_ONE   = LKW'(1);

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      LOCK = 2'd1,
      OVER = 2'd2
   } state_t;

   // Bit 0 is player 1, bit 1 is player 2 throughout the debounce path.
   logic [1:0]     btn;
   logic [1:0]     sync1;
   logic [1:0]     sync2;
   logic [1:0]     db;
   logic [1:0]     db_d;
   logic [DBW-1:0] db_cnt [2];
   logic [1:0]     press;

   state_t         state, state_n;
   logic [2:0]     p1_n, p2_n;
   logic [1:0]     winner_n;
   logic [LKW-1:0] lock_cnt, lock_cnt_n;

   assign btn   = {p2_btn, p1_btn};
   assign press = db & ~db_d;

   // Two-flop synchronizer and stability counter per button; the debounced
   // level only moves after DB_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync1     <= '0;
         sync2     <= '0;
         db        <= '0;
         db_d      <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         db_d  <= db;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= ~db[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_ONE;
            end
         end
      end
   end

   // Game state register and registered score/winner outputs.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state    <= PLAY;
         p1       <= '0;
         p2       <= '0;
         winner   <= '0;
         lock_cnt <= '0;
      end else begin
         state    <= state_n;
         p1       <= p1_n;
         p2       <= p2_n;
         winner   <= winner_n;
         lock_cnt <= lock_cnt_n;
      end
   end

   // Next-state logic: scoring in PLAY, countdown in LOCK, freeze in OVER;
   // new_game overrides everything including a same-cycle press.
   always_comb begin
      state_n    = state;
      p1_n       = p1;
      p2_n       = p2;
      winner_n   = winner;
      lock_cnt_n = lock_cnt;

      case (state)
         PLAY: begin
            if (press[0] && press[1]) begin
               // Simultaneous presses void the point but still lock out.
               state_n    = LOCK;
               lock_cnt_n = LK_LOAD;
            end else if (press[0]) begin
               p1_n = p1 + 3'd1;
               if (p1 + 3'd1 == WIN_SCORE) begin
                  state_n  = OVER;
                  winner_n = 2'b01;
               end else begin
                  state_n    = LOCK;
                  lock_cnt_n = LK_LOAD;
               end
            end else if (press[1]) begin
               p2_n = p2 + 3'd1;
               if (p2 + 3'd1 == WIN_SCORE) begin
                  state_n  = OVER;
                  winner_n = 2'b10;
               end else begin
                  state_n    = LOCK;
                  lock_cnt_n = LK_LOAD;
               end
            end
         end
         LOCK: begin
            if (lock_cnt == '0) begin
               state_n = PLAY;
            end else begin
               lock_cnt_n = lock_cnt - LK_ONE;
            end
         end
         OVER: begin
            state_n = OVER;
         end
         default: begin
            state_n = PLAY;
         end
      endcase

      if (new_game) begin
         state_n    = PLAY;
         p1_n       = '0;
         p2_n       = '0;
         winner_n   = '0;
         lock_cnt_n = '0;
      end
   end

   assign game_over = (state == OVER);
   assign locked    = (state == LOCK);

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed scenarios plus randomized button activity,
// every cycle compared against a history-based reference model.
module tb_score_keeper;

   localparam int         DB  = 4;
   localparam int         LK  = 8;
   localparam logic [2:0] WIN = 3'd5;

   logic       clk = 1'b0;
   logic       clr_n;
   logic       p1_btn;
   logic       p2_btn;
   logic       new_game;
   logic [2:0] p1;
   logic [2:0] p2;
   logic       game_over;
   logic [1:0] winner;
   logic       locked;

   int checks   = 0;
   int failures = 0;

   score_keeper #(
      .WIN_SCORE  (WIN),
      .DB_CYCLES  (DB),
      .LOCK_CYCLES(LK)
   ) dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .p1_btn   (p1_btn),
      .p2_btn   (p2_btn),
      .new_game (new_game),
      .p1       (p1),
      .p2       (p2),
      .game_over(game_over),
      .winner   (winner),
      .locked   (locked)
   );

   always #5 clk = ~clk;

   // Reference model: raw samples per edge since reset, debounced levels,
   // scores, and the absolute edge number at which a lockout ends.
   bit h1[$];
   bit h2[$];
   int e;
   bit mdb1, mdb2, mdb1_last, mdb2_last;
   int msc1, msc2, mwin, mst, lock_end;   // mst: 0 play, 1 lock, 2 over

   task automatic model_reset();
      h1.delete();
      h2.delete();
      e = 0;
      mdb1 = 0; mdb2 = 0; mdb1_last = 0; mdb2_last = 0;
      msc1 = 0; msc2 = 0; mwin = 0; mst = 0; lock_end = 0;
   endtask

   // True when the synchronized level seen at the last DB edges all
   // disagree with lvl (raw sampled two edges earlier; pre-reset is 0).
   function automatic bit all_differ(input int which, input bit lvl);
      for (int j = 0; j < DB; j++) begin
         int idx;
         bit v;
         idx = e - 2 - j;
         v = 1'b0;
         if (idx >= 0) v = (which == 1) ? h1[idx] : h2[idx];
         if (v == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_edge(input bit b1, input bit b2, input bit ng);
      bit pr1, pr2, f1, f2;
      pr1 = mdb1 && !mdb1_last;
      pr2 = mdb2 && !mdb2_last;
      if (ng) begin
         msc1 = 0; msc2 = 0; mwin = 0; mst = 0;
      end else if (mst == 0) begin
         if (pr1 && pr2) begin
            mst = 1; lock_end = e + LK;
         end else if (pr1) begin
            msc1++;
            if (msc1 == WIN) begin mst = 2; mwin = 1; end
            else begin mst = 1; lock_end = e + LK; end
         end else if (pr2) begin
            msc2++;
            if (msc2 == WIN) begin mst = 2; mwin = 2; end
            else begin mst = 1; lock_end = e + LK; end
         end
      end else if (mst == 1) begin
         if (e >= lock_end) mst = 0;
      end
      f1 = all_differ(1, mdb1);
      f2 = all_differ(2, mdb2);
      mdb1_last = mdb1;
      mdb2_last = mdb2;
      if (f1) mdb1 = !mdb1;
      if (f2) mdb2 = !mdb2;
      h1.push_back(b1);
      h2.push_back(b2);
      e++;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string where);
      check({where, ".p1"},        {5'd0, p1},        8'(msc1));
      check({where, ".p2"},        {5'd0, p2},        8'(msc2));
      check({where, ".game_over"}, {7'd0, game_over}, 8'(mst == 2));
      check({where, ".winner"},    {6'd0, winner},    8'(mwin));
      check({where, ".locked"},    {7'd0, locked},    8'(mst == 1));
   endtask

   task automatic step(input bit b1, input bit b2, input bit ng);
      p1_btn   = b1;
      p2_btn   = b2;
      new_game = ng;
      @(posedge clk);
      model_edge(b1, b2, ng);
      #1;
      check_all("cyc");
   endtask

   // Asserts clr_n between edges, checks the outputs clear without a clock,
   // holds it across one edge and releases on a falling edge.
   task automatic do_reset();
      #2;
      clr_n = 1'b0;
      #1;
      model_reset();
      check_all("rst");
      @(posedge clk);
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   task automatic press_p1();
      repeat (8)  step(1'b1, 1'b0, 1'b0);
      repeat (12) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int lc;
      clr_n    = 1'b0;
      p1_btn   = 1'b0;
      p2_btn   = 1'b0;
      new_game = 1'b0;
      model_reset();
      do_reset();
      check("reset.p1",     {5'd0, p1},     8'd0);
      check("reset.winner", {6'd0, winner}, 8'd0);

      // Single held p1 press: score appears six edges after the first sample.
      step(1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b0, 1'b0);
      check("s1.p1_before", {5'd0, p1}, 8'd0);
      step(1'b1, 1'b0, 1'b0);
      check("s1.p1_after", {5'd0, p1}, 8'd1);
      lc = int'(locked);
      for (int i = 0; i < 13; i++) begin
         step(1'b1, 1'b0, 1'b0);
         lc += int'(locked);
      end
      check("s1.lock_len", 8'(lc), 8'd8);
      check("s1.p2", {5'd0, p2}, 8'd0);
      repeat (10) step(1'b0, 1'b0, 1'b0);

      // Short p2 glitches are rejected.
      lc = 0;
      for (int i = 0; i < 4; i++) begin
         repeat (3) begin step(1'b0, 1'b1, 1'b0); lc += int'(locked); end
         repeat (3) begin step(1'b0, 1'b0, 1'b0); lc += int'(locked); end
      end
      check("s2.p2", {5'd0, p2}, 8'd0);
      check("s2.locked_seen", 8'(lc), 8'd0);

      // Simultaneous presses void the point but lock out.
      lc = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b0);
         lc += int'(locked);
      end
      check("s3.lock_len", 8'(lc), 8'd8);
      check("s3.p1", {5'd0, p1}, 8'd1);
      check("s3.p2", {5'd0, p2}, 8'd0);
      repeat (10) step(1'b0, 1'b0, 1'b0);

      // Fresh game, five p1 points win; a later p2 press changes nothing.
      step(1'b0, 1'b0, 1'b1);
      check("s4.cleared", {5'd0, p1}, 8'd0);
      repeat (5) press_p1();
      check("s4.p1",        {5'd0, p1},        8'd5);
      check("s4.game_over", {7'd0, game_over}, 8'd1);
      check("s4.winner",    {6'd0, winner},    8'd1);
      repeat (8) step(1'b0, 1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b0, 1'b0);
      check("s4.p2_frozen",  {5'd0, p2},     8'd0);
      check("s4.win_frozen", {6'd0, winner}, 8'd1);

      // new_game while p1 is held: no score until release and re-press.
      repeat (8) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("s5.p1",        {5'd0, p1},        8'd0);
      check("s5.winner",    {6'd0, winner},    8'd0);
      check("s5.game_over", {7'd0, game_over}, 8'd0);
      repeat (20) step(1'b1, 1'b0, 1'b0);
      check("s5.held_p1", {5'd0, p1}, 8'd0);
      repeat (10) step(1'b0, 1'b0, 1'b0);
      press_p1();
      check("s5.repress_p1", {5'd0, p1}, 8'd1);

      // Reset in the middle of a lockout with p1 at 3.
      press_p1();
      repeat (8) step(1'b1, 1'b0, 1'b0);
      check("s6.p1_pre",     {5'd0, p1},     8'd3);
      check("s6.locked_pre", {7'd0, locked}, 8'd1);
      do_reset();
      check("s6.p1_rst",     {5'd0, p1},     8'd0);
      check("s6.locked_rst", {7'd0, locked}, 8'd0);
      repeat (8) step(1'b1, 1'b0, 1'b0);
      check("s6.p1_post", {5'd0, p1}, 8'd1);
      repeat (12) step(1'b0, 1'b0, 1'b0);

      // Randomized button activity with occasional new_game and reset.
      for (int s = 0; s < 300; s++) begin
         bit b1, b2, ng;
         int len;
         b1  = 1'($urandom_range(0, 1));
         b2  = 1'($urandom_range(0, 1));
         ng  = ($urandom_range(0, 30) == 0);
         len = $urandom_range(1, 12);
         step(b1, b2, ng);
         for (int i = 1; i < len; i++) step(b1, b2, 1'b0);
         if ($urandom_range(0, 60) == 0) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
